// File: rtl/tt_ctrl_seq_pkg.sv
// Shared constants and helpers for the mux-controller select sequencer.
package tt_ctrl_seq_pkg;

  // Default select counter width and phase timings for the TT mux controller.
  localparam int TT_SEL_W   = 10;
  localparam int TT_PULSE_W = 2;
  localparam int TT_RST_W   = 4;

  // Width of a down-counter able to hold the longest phase length.
  function automatic int timer_width(input int pulse_w, input int rst_w);
    int m;
    m = (pulse_w > rst_w) ? pulse_w : rst_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tt_ctrl_seq_timer.sv
// Loadable down-counter with a zero flag, used to time reset and pulse phases.
// Loading L-1 on entry to a phase makes zero rise in the phase's last cycle.
module tt_ctrl_seq_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/tt_ctrl_seq.sv
// Sequencer driving the mux controller's ripple select counter
// (ctrl_sel_rst_n / ctrl_sel_inc / ctrl_ena). Moves forward by pulsing only
// the address delta, otherwise resets the counter and counts up from zero.
// Every pad-facing output comes straight from a flop so the ripple counter
// never sees a combinational glitch.
module tt_ctrl_seq
  import tt_ctrl_seq_pkg::*;
#(
  parameter int SEL_W   = TT_SEL_W,
  parameter int PULSE_W = TT_PULSE_W,
  parameter int RST_W   = TT_RST_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_addr,
  input  logic             req_ena,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] cur_addr,
  output logic             cur_valid,
  output logic             ctrl_sel_rst_n,
  output logic             ctrl_sel_inc,
  output logic             ctrl_ena
);

  localparam int TW = timer_width(PULSE_W, RST_W);

  typedef enum logic [2:0] {IDLE, DIS, RST, INC_H, INC_L, EN} state_t;

  state_t           state_reg, state_next;
  logic             full_reg, ena_reg, cur_valid_reg;
  logic [SEL_W-1:0] pcnt_reg, cur_addr_reg;
  logic             rst_n_reg, inc_reg, ena_out_reg, done_reg, busy_reg;
  logic             rst_n_next, inc_next, ena_out_next, done_next, busy_next;
  logic             accept, take_full;
  logic             timer_load, timer_zero;
  logic [TW-1:0]    timer_val;

  assign accept    = req_valid && (state_reg == IDLE);
  assign take_full = !cur_valid_reg || (req_addr < cur_addr_reg);

  tt_ctrl_seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // State register plus the request/address bookkeeping it depends on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      full_reg      <= 1'b0;
      ena_reg       <= 1'b0;
      pcnt_reg      <= '0;
      cur_addr_reg  <= '0;
      cur_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        full_reg <= take_full;
        ena_reg  <= req_ena;
        pcnt_reg <= take_full ? req_addr : (req_addr - cur_addr_reg);
      end
      if (state_reg == RST && timer_zero) begin
        cur_addr_reg  <= '0;
        cur_valid_reg <= 1'b1;
      end
      if (state_reg == INC_H && timer_zero) begin
        cur_addr_reg <= cur_addr_reg + 1'b1;
        pcnt_reg     <= pcnt_reg - 1'b1;
      end
    end
  end

  // Next-state selection; phases end when the timer reaches zero.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = DIS;
      DIS:     state_next = full_reg ? RST : ((pcnt_reg != '0) ? INC_H : EN);
      RST:     if (timer_zero) state_next = (pcnt_reg != '0) ? INC_H : EN;
      INC_H:   if (timer_zero) state_next = INC_L;
      INC_L:   if (timer_zero) state_next = (pcnt_reg != '0) ? INC_H : EN;
      EN:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and the timer load for the next phase.
  always_comb begin
    rst_n_next   = rst_n_reg;
    ena_out_next = ena_out_reg;
    inc_next     = (state_next == INC_H);
    done_next    = (state_next == EN);
    busy_next    = (state_next != IDLE);
    if (state_next == RST)       rst_n_next = 1'b0;
    else if (state_reg == RST)   rst_n_next = 1'b1;
    if (state_next == DIS)       ena_out_next = 1'b0;
    else if (state_next == EN)   ena_out_next = ena_reg;
    timer_load = (state_next != state_reg);
    case (state_next)
      RST:          timer_val = TW'(RST_W - 1);
      INC_H, INC_L: timer_val = TW'(PULSE_W - 1);
      default:      timer_val = '0;
    endcase
  end

  // Output flops; the select counter is held in reset until the first full reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_n_reg   <= 1'b0;
      inc_reg     <= 1'b0;
      ena_out_reg <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      rst_n_reg   <= rst_n_next;
      inc_reg     <= inc_next;
      ena_out_reg <= ena_out_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
    end
  end

  assign req_ready      = (state_reg == IDLE);
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign cur_addr       = cur_addr_reg;
  assign cur_valid      = cur_valid_reg;
  assign ctrl_sel_rst_n = rst_n_reg;
  assign ctrl_sel_inc   = inc_reg;
  assign ctrl_ena       = ena_out_reg;

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Scoreboard bench for tt_ctrl_seq: the driver pushes expected outcomes computed
// from the address rules, a negedge monitor measures each sequence and compares.
module tb_tt_ctrl_seq;

  localparam int SEL_W   = 10;
  localparam int PULSE_W = 2;
  localparam int RST_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ena = 1'b0;
  logic [SEL_W-1:0] req_addr = '0;
  logic             req_ready, busy, done, cur_valid;
  logic             ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
  logic [SEL_W-1:0] cur_addr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int lat;
    int addr;
    int ena;
    int rst_low;
    int inc_edges;
  } exp_t;

  exp_t exp_q[$];
  int   m_cur   = 0;
  bit   m_valid = 0;

  always #5 clk = ~clk;

  tt_ctrl_seq #(.SEL_W(SEL_W), .PULSE_W(PULSE_W), .RST_W(RST_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_ena        (req_ena),
    .busy           (busy),
    .done           (done),
    .cur_addr       (cur_addr),
    .cur_valid      (cur_valid),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: measures latency, reset-low cycles and inc edges per sequence.
  bit   in_flight = 0;
  int   cyc, rst_low, inc_edges;
  logic prev_inc;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      in_flight = 0;
    end else begin
      if (in_flight) begin
        cyc++;
        if (!ctrl_sel_rst_n) rst_low++;
        if (ctrl_sel_inc && !prev_inc) inc_edges++;
        prev_inc = ctrl_sel_inc;
        if (cyc == 1) check("dis_ena", int'(ctrl_ena), 0);
        if (done) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL done_without_request: got done=1, expected no pending request");
          end else begin
            mon_e = exp_q.pop_front();
            check("latency",   cyc - 1,          mon_e.lat);
            check("cur_addr",  int'(cur_addr),   mon_e.addr);
            check("cur_valid", int'(cur_valid),  1);
            check("ctrl_ena",  int'(ctrl_ena),   mon_e.ena);
            check("rst_low",   rst_low,          mon_e.rst_low);
            check("inc_edges", inc_edges,        mon_e.inc_edges);
            $display("[TB] txn addr=%0d ena=%0d latency=%0d rst_low=%0d inc_edges=%0d",
                     cur_addr, ctrl_ena, cyc - 1, rst_low, inc_edges);
          end
          in_flight = 0;
        end else if (cyc > 6000) begin
          tests++; fails++;
          $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          in_flight = 0;
        end
      end else if (done) begin
        tests++; fails++;
        $display("FAIL spurious_done: got done=1 while idle, expected 0");
      end
      if (req_valid && req_ready) begin
        if (in_flight) begin
          tests++; fails++;
          $display("FAIL accept_while_busy: got ready=1 mid-sequence, expected 0");
        end
        in_flight = 1;
        cyc       = 0;
        rst_low   = 0;
        inc_edges = 0;
        prev_inc  = ctrl_sel_inc;
      end
    end
  end

  // Present one request, predict its outcome, and release (or hold) after accept.
  task automatic issue(input int a, input bit e, input bit hold, input int a2, input bit e2);
    exp_t x;
    bit   full;
    int   n;
    int   guard;
    guard = 0;
    while (!req_ready) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 10000) begin
        $display("FAIL ready_timeout: got ready=0 for %0d cycles, expected 1", guard);
        $fatal(1, "bench stopped");
      end
    end
    req_valid = 1'b1;
    req_addr  = SEL_W'(a);
    req_ena   = e;
    full = !m_valid || (a < m_cur);
    n    = full ? a : a - m_cur;
    x.lat       = 1 + (full ? RST_W : 0) + 2 * PULSE_W * n;
    x.addr      = a;
    x.ena       = int'(e);
    x.rst_low   = full ? RST_W + (m_valid ? 0 : 1) : 0;
    x.inc_edges = n;
    exp_q.push_back(x);
    m_cur   = a;
    m_valid = 1;
    @(posedge clk); #1;
    if (hold) begin
      req_addr = SEL_W'(a2);
      req_ena  = e2;
    end else begin
      req_valid = 1'b0;
      req_addr  = SEL_W'($urandom);
      req_ena   = 1'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst_n"},     int'(ctrl_sel_rst_n), 0);
    check({tag, "_inc"},       int'(ctrl_sel_inc),   0);
    check({tag, "_ena"},       int'(ctrl_ena),       0);
    check({tag, "_cur_addr"},  int'(cur_addr),       0);
    check({tag, "_cur_valid"}, int'(cur_valid),      0);
    check({tag, "_done"},      int'(done),           0);
    check({tag, "_busy"},      int'(busy),           0);
  endtask

  initial begin
    int guard;
    int a;
    bit e;

    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", int'(req_ready), 1);
    check_reset_outputs("post_reset");
    @(posedge clk); #1;

    issue(3, 1, 0, 0, 0);
    issue(5, 1, 0, 0, 0);
    issue(2, 1, 0, 0, 0);
    issue(2, 0, 0, 0, 0);

    // Reset asserted between clock edges while an increment pulse is high.
    issue(10, 1, 0, 0, 0);
    guard = 0;
    while (!ctrl_sel_inc && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_inc_seen", int'(ctrl_sel_inc), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    m_valid = 0;
    m_cur   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-range sweep with a second request held valid the whole time.
    issue(1023, 1, 1, 7, 0);
    issue(7, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 40);
      if ($urandom_range(0, 3) == 0) a = m_cur;
      e = 1'($urandom_range(0, 1));
      issue(a, e, 0, 0, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    guard = 0;
    while ((exp_q.size() != 0 || in_flight) && guard < 10000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("queue_drained", exp_q.size(), 0);
    check("idle_at_end", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
